// File: rtl/hex_seq_ctrl.sv
// hex_seq_ctrl: steps a position pointer through a small table of hex digits,
// either automatically (one advance every TICK_DIV cycles while run is held)
// or one position per rising edge of step. The table is loadable only while
// idle, and the digit at the current position drives a 7-segment display.
module hex_seq_ctrl #(
    parameter int N_DIGITS = 5,
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dir,
    input  logic       run,
    input  logic       step,
    input  logic       ld_valid,
    input  logic [2:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic       ld_ready,
    output logic [6:0] hex,
    output logic [2:0] pos,
    output logic       wrap
);

    localparam int            TW        = $clog2(TICK_DIV);
    localparam logic [2:0]    LAST      = 3'(N_DIGITS - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STEP
    } state_t;

    state_t                     state_q, state_d;
    logic [TW-1:0]              tick_q, tick_d;
    logic [2:0]                 pos_q, pos_d;
    logic                       wrap_q, wrap_d;
    logic                       step_q;
    logic [N_DIGITS-1:0][3:0]   tab_q, tab_d;

    logic                       step_edge;
    logic [2:0]                 pos_nxt;
    logic                       pos_wrap;
    logic [3:0]                 digit;

    // step_q is cleared by reset, so a step held high across release still
    // counts as a fresh edge on the first clock.
    assign step_edge = step & ~step_q;

    // Candidate next position (modulo N_DIGITS) and whether moving there wraps.
    always_comb begin
        pos_nxt  = pos_q;
        pos_wrap = 1'b0;
        if (dir) begin
            if (pos_q == 3'd0) begin
                pos_nxt  = LAST;
                pos_wrap = 1'b1;
            end else begin
                pos_nxt = pos_q - 3'd1;
            end
        end else begin
            if (pos_q == LAST) begin
                pos_nxt  = 3'd0;
                pos_wrap = 1'b1;
            end else begin
                pos_nxt = pos_q + 3'd1;
            end
        end
    end

    // State register; reset abandons any run/step in flight and reloads the table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            pos_q   <= '0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                tab_q[i] <= 4'(i);
            end
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            pos_q   <= pos_d;
            wrap_q  <= wrap_d;
            step_q  <= step;
            tab_q   <= tab_d;
        end
    end

    // Next-state logic: IDLE priority is load > run > step edge.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        pos_d   = pos_q;
        wrap_d  = 1'b0;
        tab_d   = tab_q;
        case (state_q)
            S_IDLE: begin
                if (ld_valid) begin
                    // Out-of-range addresses are accepted but match no entry.
                    for (int i = 0; i < N_DIGITS; i++) begin
                        if (ld_addr == 3'(i)) begin
                            tab_d[i] = ld_data;
                        end
                    end
                end else if (run) begin
                    state_d = S_RUN;
                    tick_d  = '0;
                end else if (step_edge) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run) begin
                    // Dropping run discards the partial interval.
                    state_d = S_IDLE;
                    tick_d  = '0;
                end else if (tick_q == TICK_LAST) begin
                    pos_d  = pos_nxt;
                    wrap_d = pos_wrap;
                    tick_d = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            S_STEP: begin
                pos_d   = pos_nxt;
                wrap_d  = pos_wrap;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: load handshake, position, wrap pulse and 7-segment decode.
    always_comb begin
        ld_ready = (state_q == S_IDLE);
        pos      = pos_q;
        wrap     = wrap_q;
        digit    = tab_q[0];
        for (int i = 0; i < N_DIGITS; i++) begin
            if (pos_q == 3'(i)) begin
                digit = tab_q[i];
            end
        end
        case (digit)
            4'h0:    hex = 7'b1000000;
            4'h1:    hex = 7'b1111001;
            4'h2:    hex = 7'b0100100;
            4'h3:    hex = 7'b0110000;
            4'h4:    hex = 7'b0011001;
            4'h5:    hex = 7'b0010010;
            4'h6:    hex = 7'b0000010;
            4'h7:    hex = 7'b1111000;
            4'h8:    hex = 7'b0000000;
            4'h9:    hex = 7'b0010000;
            4'hA:    hex = 7'b0001000;
            4'hB:    hex = 7'b0000011;
            4'hC:    hex = 7'b1000110;
            4'hD:    hex = 7'b0100001;
            4'hE:    hex = 7'b0000110;
            default: hex = 7'b0001110;
        endcase
    end

endmodule
